// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks {A,B,C,D} through all 16 minterms, captures F and grades it against EXPECTED.
// Latency 16*SETTLE_CYCLES+1 cycles from START to DONE; START is only honoured in IDLE, ignored otherwise.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 2,        // legal range 1..15
    parameter logic [15:0] EXPECTED      = 16'hE188
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  logic        F,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] CAPTURED,
    output logic [4:0]  MISMATCH_CNT,
    output logic [3:0]  FAIL_IDX
);

    typedef enum logic [1:0] {IDLE, SWEEP, REPORT} state_t;

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  idx, cnt;
    logic        sample, last;
    logic [15:0] cap_nxt, diff_nxt;
    logic [4:0]  pop_nxt;
    logic [3:0]  fidx_nxt;

    assign sample = (state == SWEEP) && (cnt == 4'd0);
    assign last   = sample && (idx == 4'd15);

    // Grade the table including the bit being sampled on this edge, so the
    // results are already registered when REPORT (and DONE) begins.
    always_comb begin
        cap_nxt      = CAPTURED;
        cap_nxt[idx] = F;
    end

    assign diff_nxt = cap_nxt ^ EXPECTED;

    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < 16; i++)
            pop_nxt = pop_nxt + 5'(diff_nxt[i]);
    end

    always_comb begin
        fidx_nxt = '0;
        for (int i = 15; i >= 0; i--)
            if (diff_nxt[i]) fidx_nxt = 4'(i);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (START) state_nxt = SWEEP;
            SWEEP:   if (last)  state_nxt = REPORT;
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        {A, B, C, D} = (state == SWEEP) ? idx : 4'd0;
        BUSY         = (state == SWEEP);
        DONE         = (state == REPORT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            idx          <= '0;
            cnt          <= '0;
            CAPTURED     <= '0;
            PASS         <= 1'b0;
            MISMATCH_CNT <= '0;
            FAIL_IDX     <= '0;
        end else if (state == IDLE && START) begin
            idx          <= '0;
            cnt          <= RELOAD;
            CAPTURED     <= '0;
            PASS         <= 1'b0;
            MISMATCH_CNT <= '0;
            FAIL_IDX     <= '0;
        end else if (state == SWEEP) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                CAPTURED <= cap_nxt;
                if (idx == 4'd15) begin
                    idx          <= '0;
                    PASS         <= (diff_nxt == 16'd0);
                    MISMATCH_CNT <= pop_nxt;
                    FAIL_IDX     <= fidx_nxt;
                end else begin
                    idx <= idx + 4'd1;
                    cnt <= RELOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweeper instances (settle 2 with a modelled function block, settle 1 with F tied high).
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start1, start2;
    logic        f1, f2;
    logic        a1, b1, c1, d1, busy1, done1, pass1;
    logic        a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] cap1, cap2;
    logic [4:0]  mc1, mc2;
    logic [3:0]  fi1, fi2;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fmode = 0;   // 0: lab function, 1: tied low, 2: lab function with minterm 8 flipped
    int osel  = 0;   // which instance the observation wires follow

    always @(posedge clk) cyc <= cyc + 1;

    // Reduced-POS lab function written out as sum-of-products.
    function automatic logic fmodel(input logic [3:0] m);
        logic a, b, c, d;
        {a, b, c, d} = m;
        return (~a & c & d) | (a & ~b & ~c & ~d) | (a & b & d) | (a & b & c);
    endfunction

    assign f1 = (fmode == 1) ? 1'b0 : (fmodel({a1, b1, c1, d1}) ^ (fmode == 2 && {a1, b1, c1, d1} == 4'd8));
    assign f2 = 1'b1;

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .F(f1),
        .A(a1), .B(b1), .C(c1), .D(d1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .CAPTURED(cap1), .MISMATCH_CNT(mc1), .FAIL_IDX(fi1)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(16'hE188)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .F(f2),
        .A(a2), .B(b2), .C(c2), .D(d2), .BUSY(busy2), .DONE(done2), .PASS(pass2),
        .CAPTURED(cap2), .MISMATCH_CNT(mc2), .FAIL_IDX(fi2)
    );

    logic [3:0]  o_abcd;
    logic        o_busy, o_done, o_pass;
    logic [15:0] o_cap;
    logic [4:0]  o_mc;
    logic [3:0]  o_fi;
    assign o_abcd = osel ? {a2, b2, c2, d2} : {a1, b1, c1, d1};
    assign o_busy = osel ? busy2 : busy1;
    assign o_done = osel ? done2 : done1;
    assign o_pass = osel ? pass2 : pass1;
    assign o_cap  = osel ? cap2  : cap1;
    assign o_mc   = osel ? mc2   : mc1;
    assign o_fi   = osel ? fi2   : fi1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " abcd"}, 32'(o_abcd), 0);
        chk({tag, " busy"}, 32'(o_busy), 0);
        chk({tag, " done"}, 32'(o_done), 0);
        chk({tag, " pass"}, 32'(o_pass), 0);
        chk({tag, " cap"},  32'(o_cap),  0);
        chk({tag, " mc"},   32'(o_mc),   0);
        chk({tag, " fi"},   32'(o_fi),   0);
    endtask

    // Pulse START for one edge (edge k), then follow the sweep to DONE.
    // cyc-k counts edges after the accepting edge: minterm = (cyc-k)/settle,
    // and DONE appears 16*settle edges later (cycle k+16*settle+1 in 1-based terms).
    task automatic sweep(input int sel, input int settle, input logic [15:0] ecap,
                         input logic epass, input logic [4:0] emc, input logic [3:0] efi,
                         input string tag);
        int  k, busy_n;
        bit  seen, step_ok;
        osel = sel;
        @(posedge clk); #1;
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        k = cyc;
        start1 = 1'b0;
        start2 = 1'b0;
        seen = 0; busy_n = 0; step_ok = 1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (o_done) seen = 1;
            else if (o_busy) begin
                busy_n++;
                if (o_abcd != 4'((cyc - k) / settle)) step_ok = 0;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 1);
        chk({tag, " latency"},   32'(cyc - k), 32'(16 * settle));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(16 * settle));
        chk({tag, " minterm steps"}, 32'(step_ok), 1);
        chk({tag, " cap"},  32'(o_cap),  32'(ecap));
        chk({tag, " pass"}, 32'(o_pass), 32'(epass));
        chk({tag, " mc"},   32'(o_mc),   32'(emc));
        chk({tag, " fi"},   32'(o_fi),   32'(efi));
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(o_done), 0);
        chk({tag, " idle abcd"}, 32'(o_abcd), 0);
        repeat (3) @(negedge clk);
        chk({tag, " cap held"},  32'(o_cap),  32'(ecap));
        chk({tag, " pass held"}, 32'(o_pass), 32'(epass));
    endtask

    initial begin
        int  k, dones, lat;
        bit  found;

        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (2) @(negedge clk);
        osel = 0; chk_all_zero("reset dut1");
        osel = 1; chk_all_zero("reset dut2");
        rst_n = 1'b1;

        fmode = 0; sweep(0, 2, 16'hE188, 1'b1, 5'd0,  4'd0, "lab fn");
        fmode = 1; sweep(0, 2, 16'h0000, 1'b0, 5'd6,  4'd3, "tied0");
        fmode = 2; sweep(0, 2, 16'hE088, 1'b0, 5'd1,  4'd8, "flip8");

        // Reset mid-sweep at minterm 5, after some ones are already captured.
        fmode = 0; osel = 0;
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if ({a1, b1, c1, d1} == 4'd5) found = 1;
        end
        chk("reach idx5", 32'(found), 1);
        chk("cap before reset", 32'(cap1), 32'h0008);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done1) dones++;
        end
        chk("no done after reset", 32'(dones), 0);
        sweep(0, 2, 16'hE188, 1'b1, 5'd0, 4'd0, "after reset");

        // START re-pulsed mid-sweep must not restart or queue a second sweep.
        osel = 0;
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0; k = cyc;
        dones = 0; lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 10) start1 = 1'b1;
            if (i == 12) start1 = 1'b0;
            if (done1) begin
                dones++;
                if (lat < 0) lat = cyc - k;
            end
        end
        chk("restart ignored dones", 32'(dones), 1);
        chk("restart ignored latency", 32'(lat), 32);
        chk("restart ignored cap", 32'(cap1), 32'hE188);

        // START held high: back-to-back sweeps separated by one IDLE cycle.
        @(posedge clk); #1; start1 = 1'b1;
        @(posedge clk); #1; k = cyc;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (done1) found = 1;
        end
        chk("held done seen", 32'(found), 1);
        chk("held latency", 32'(cyc - k), 32);
        @(negedge clk);
        chk("held idle busy", 32'(busy1), 0);
        chk("held idle done", 32'(done1), 0);
        chk("held idle cap", 32'(cap1), 32'hE188);
        @(negedge clk);
        chk("held restart busy", 32'(busy1), 1);
        chk("held restart cap cleared", 32'(cap1), 0);
        chk("held restart pass cleared", 32'(pass1), 0);
        start1 = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (done1) found = 1;
        end
        chk("held second done", 32'(found), 1);
        chk("held second cap", 32'(cap1), 32'hE188);

        sweep(1, 1, 16'hFFFF, 1'b0, 5'd10, 4'd0, "settle1 tied1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-checking stimulus/capture stage that sits directly upstream and downstream of the lab's 4-input combinational function blocks. It drives A,B,C,D through all 16 minterms (A = MSB) and samples the block's single output after a settle window. It assembles the 16-bit truth table and compares it against a parameterised expected mask. It reports pass/fail, the mismatch count and the first failing minterm.

Parameters:
SETTLE_CYCLES, 2, clock cycles each minterm is held; F is sampled on the last one; legal range 1..15
EXPECTED, 16'hE188, expected truth table, bit i = F for {A,B,C,D}=i (default = reduced-POS lab function, ones at minterms 3,7,8,13,14,15)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
START  input  1  level; accepted only in IDLE
F  input  1  output of the function block under test
A  output  1  minterm bit 3 (MSB) to block under test
B  output  1  minterm bit 2
C  output  1  minterm bit 1
D  output  1  minterm bit 0 (LSB)
BUSY  output  1  high during SWEEP
DONE  output  1  one-cycle pulse when results valid
PASS  output  1  CAPTURED == EXPECTED, valid from DONE
CAPTURED  output  16  captured truth table
MISMATCH_CNT  output  5  popcount(CAPTURED ^ EXPECTED), 0..16
FAIL_IDX  output  4  lowest mismatching minterm index; 0 when PASS

Behaviour:
- One clock CLK; reset RST_N asynchronous, active-low; all state registered.
- Reset values: A,B,C,D=0, BUSY=0, DONE=0, PASS=0, CAPTURED=0, MISMATCH_CNT=0, FAIL_IDX=0, state IDLE, idx=0, cnt=0.
- Internal registers: 4-bit idx, 4-bit settle counter cnt.
- {A,B,C,D} = idx during SWEEP; 0 in IDLE and REPORT.
- IDLE: on an edge with START=1, go to SWEEP. Set idx=0 and cnt=SETTLE_CYCLES-1. Clear CAPTURED, PASS, MISMATCH_CNT and FAIL_IDX.
- SWEEP, BUSY=1, each edge:
  - If cnt!=0: cnt--.
  - If cnt==0: CAPTURED[idx] <= F.
    - If idx==15, go to REPORT.
    - Otherwise idx++ and cnt reloads to SETTLE_CYCLES-1.
- Each minterm is presented for exactly SETTLE_CYCLES cycles. F is sampled at the end of the last of them.
- REPORT, BUSY=0: DONE=1 for this single cycle. PASS, MISMATCH_CNT and FAIL_IDX become valid in this cycle. These use the complete CAPTURED, including bit 15 sampled on the preceding edge. Next state is IDLE unconditionally.
- Latency: START accepted at edge k → SWEEP occupies cycles k+1 .. k+16·SETTLE_CYCLES → DONE high in cycle k+16·SETTLE_CYCLES+1.
- Results (PASS, CAPTURED, MISMATCH_CNT, FAIL_IDX) hold until the next accepted START.
- START asserted in SWEEP or REPORT is ignored. It is neither queued nor restarted.
- START held high continuously gives back-to-back sweeps. There is exactly one IDLE cycle between DONE and the next BUSY.
- F is treated as synchronous to CLK (combinational function of A..D); no synchroniser.
- RST_N low at any point, including mid-sweep, forces all reset values immediately. The sweep is abandoned and no DONE pulse is produced.
- FAIL_IDX: priority encoder, lowest set bit of CAPTURED^EXPECTED.
- MISMATCH_CNT: 5-bit, so 16 mismatches is representable.

Test Plan:
- SETTLE_CYCLES=2, F driven by the reduced-POS function model, START 1-cycle pulse at edge k → DONE at cycle k+33, CAPTURED=16'hE188, PASS=1, MISMATCH_CNT=0, FAIL_IDX=0; A..D step 0..15, two cycles each.
- F tied 0 → CAPTURED=16'h0000, PASS=0, MISMATCH_CNT=6, FAIL_IDX=3.
- F = function model with minterm 8 inverted → CAPTURED=16'hE088, MISMATCH_CNT=1, FAIL_IDX=8.
- RST_N pulsed low while idx=5 →
  - all outputs 0 asynchronously, no DONE;
  - a fresh START then yields the full correct result with latency k+33.
- START re-pulsed mid-sweep → ignored, single DONE at k+33. START held high → DONE, one IDLE cycle with BUSY=0, then BUSY=1 again, CAPTURED cleared at restart.
- SETTLE_CYCLES=1, F tied 1 → A..D = 0..15 one per cycle, DONE at k+17, CAPTURED=16'hFFFF, MISMATCH_CNT=10, FAIL_IDX=0.
